piso_serializer: RTL
====================

// Module: piso_serializer
// PURPOSE
//  Parallel-in/serial-out stage that feeds the serial input of sipo_reg.
//  Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clk.
//  so_valid qualifies each bit, and frame_done marks the final bit.
//  Back-to-back words stream gaplessly, so the downstream SIPO sees a continuous bit stream.
// PARAMETERS
//  WIDTH      4  data word width; legal values are 2..32.
//  MSB_FIRST  1  1: din[WIDTH-1] is sent first. 0: din[0] is sent first.
// PORTS
//  clk        in   1      rising-edge clock.
//  clear      in   1      asynchronous reset, active-high.
//  din        in   WIDTH  parallel word.
//  din_valid  in   1      din holds a word to send.
//  din_ready  out  1      block can take a word; a transfer occurs when din_valid & din_ready at a rising clk edge.
//  so         out  1      serial data bit; connects to the sipo_reg serial input.
//  so_valid   out  1      so carries a frame bit this cycle.
//  frame_done out  1      1-cycle pulse coincident with the last bit of a frame.
// BEHAVIOUR
//  Clock and reset:
//  - One clock, clk. clear is asynchronous and active-high.
//  - All outputs are registered.
//  Reset values:
//  - so=0, so_valid=0, frame_done=0, din_ready=0, FSM=IDLE, shift register=0, bit counter=0.
//  - din_ready rises 1 clk after clear deasserts.
//  FSM states: IDLE, SHIFT, PAR. PAR exists only with PARITY_EN.
//  - IDLE: din_ready=1 and so=0. On a handshake, load din and go to SHIFT.
//  - SHIFT: drives one data bit per cycle with so_valid=1, WIDTH cycles in total.
//    After the last data bit: go to PAR if PARITY_EN is defined, else end the frame.
//  - PAR: drives the parity bit for 1 cycle with so_valid=1, then ends the frame.
//  - End of frame: go to SHIFT if a new word was accepted in the final-bit cycle, else go to IDLE.
//  Latency:
//  - Handshake at edge N puts the first bit on so during cycle N+1.
//  - The frame occupies exactly WIDTH cycles, or WIDTH+1 with PARITY_EN.
//  Ready rule:
//  - din_ready=1 in IDLE, and during the final-bit cycle of a frame.
//  - A word taken in the final-bit cycle starts its first bit in the next cycle, with no idle gap.
//  - din_ready=0 during all other SHIFT/PAR cycles. din_valid is ignored then; the word stays pending upstream.
//  Serial path:
//  - The shift register shifts toward the output end selected by MSB_FIRST.
//  - The bit counter counts down from WIDTH-1 and is $clog2(WIDTH) bits wide. No wrap-around is observable.
//  frame_done: high exactly in the cycle the last bit (data or parity) is on so.
//  Reset mid-frame: the frame is aborted immediately, all outputs return to reset values, and no partial frame resumes.
//  Simultaneous din_valid and clear: clear wins and the word is not accepted.
// CONFIGURATION
//  Macro: PARITY_EN.
//  - Defined: one even-parity bit (XOR of all data bits) follows the data bits, with so_valid=1 and frame_done on that bit.
//  - Undefined: frame is data bits only. The PAR state and parity logic are not compiled.
// STRUCTURE
//  Shared header sipo_defs.vh holds:
//  - FSM state localparams (ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_PAR=2'd2);
//  - the default WIDTH, shared with sipo_reg.
//  Sub-module shift_bit_counter: loadable down-counter with a terminal-count flag. It is the natural split.
//  FSM, shift register and output registers stay in piso_serializer.
// TESTING  (WIDTH=4 unless noted)
//  - After reset: clear pulse -> all outputs 0 during clear; din_ready=1 one clk after release; so stays 0 while idle.
//  - MSB_FIRST=1, din=4'b1011 for one handshake -> so=1,0,1,1 on the next 4 cycles;
//    so_valid=1 for 4 cycles; frame_done on the 4th cycle.
//  - MSB_FIRST=0, din=4'b1011 -> so=1,1,0,1.
//  - Back-to-back: din=4'hA then din=4'h5 held valid -> 8 contiguous bits 1,0,1,0,0,1,0,1;
//    so_valid never drops; frame_done on bits 4 and 8; second word accepted in the bit-4 cycle.
//  - Mid-frame reset: clear asserted during the 2nd bit of 4'hF -> so/so_valid drop to 0 asynchronously;
//    after release, a new word 4'h3 -> so=0,0,1,1.
//  - PARITY_EN with din=4'b1011 -> so=1,0,1,1,1 (parity=1); frame_done on the 5th bit;
//    din_ready=1 only in IDLE and on the parity cycle.

Source files
------------

// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the PISO serializer.
// Optional feature: PARITY_EN appends an even-parity bit to each frame.
package piso_serializer_pkg;

    // Default word width, shared with the downstream sipo_reg
    localparam int WIDTH_DEF = 4;

`ifdef PARITY_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PAR   = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1
    } state_t;
`endif

endpackage

// File: rtl/piso_serializer_counter.sv
// Loadable down-counter with terminal-count flag.
// Tracks the data bits still to be sent after the current one.
module shift_bit_counter #(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          clear,
    input  logic          load,
    input  logic          en,
    input  logic [CW-1:0] load_val,
    output logic [CW-1:0] cnt,
    output logic          tc
);

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign tc = (cnt == '0);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with valid/ready input.
// Define PARITY_EN to append an even-parity bit to every frame.
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             so,
    output logic             so_valid,
    output logic             frame_done
);

    localparam int CW = $clog2(WIDTH);

    state_t           state, state_n;
    logic [WIDTH-1:0] sreg, sreg_n;
    logic             so_n, so_valid_n;
    logic             frame_done_n, din_ready_n;
    logic             take, dec;
    logic             first_bit, head_bit, last_next;
    logic [WIDTH-1:0] din_rest, sreg_rest;
    logic [CW-1:0]    cnt;
    logic             tc;
`ifdef PARITY_EN
    logic             par, par_n;
`endif

    assign take      = din_ready & din_valid;
    assign first_bit = MSB_FIRST ? din[WIDTH-1] : din[0];
    assign head_bit  = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
    assign din_rest  = MSB_FIRST ? (din << 1) : (din >> 1);
    assign sreg_rest = MSB_FIRST ? (sreg << 1) : (sreg >> 1);
    assign last_next = (cnt == CW'(1));
    assign dec       = (state == ST_SHIFT) & ~tc & ~take;

    shift_bit_counter #(.CW(CW)) u_cnt (
        .clk      (clk),
        .clear    (clear),
        .load     (take),
        .en       (dec),
        .load_val (CW'(WIDTH - 1)),
        .cnt      (cnt),
        .tc       (tc)
    );

    always_comb begin
        state_n      = state;
        sreg_n       = sreg;
        so_n         = 1'b0;
        so_valid_n   = 1'b0;
        frame_done_n = 1'b0;
        din_ready_n  = 1'b0;
`ifdef PARITY_EN
        par_n        = par;
`endif
        if (take) begin
            // Ready is only high in IDLE or on a final bit, so a
            // handshake always starts a fresh frame next cycle.
            state_n    = ST_SHIFT;
            sreg_n     = din_rest;
            so_n       = first_bit;
            so_valid_n = 1'b1;
`ifdef PARITY_EN
            par_n      = ^din;
`endif
        end else begin
            unique case (state)
                ST_IDLE: begin
                    din_ready_n = 1'b1;
                end
                ST_SHIFT: begin
                    if (!tc) begin
                        sreg_n     = sreg_rest;
                        so_n       = head_bit;
                        so_valid_n = 1'b1;
`ifndef PARITY_EN
                        frame_done_n = last_next;
                        din_ready_n  = last_next;
`endif
                    end else begin
`ifdef PARITY_EN
                        state_n      = ST_PAR;
                        so_n         = par;
                        so_valid_n   = 1'b1;
                        frame_done_n = 1'b1;
                        din_ready_n  = 1'b1;
`else
                        state_n     = ST_IDLE;
                        din_ready_n = 1'b1;
`endif
                    end
                end
`ifdef PARITY_EN
                ST_PAR: begin
                    state_n     = ST_IDLE;
                    din_ready_n = 1'b1;
                end
`endif
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state      <= ST_IDLE;
            sreg       <= '0;
            so         <= 1'b0;
            so_valid   <= 1'b0;
            frame_done <= 1'b0;
            din_ready  <= 1'b0;
`ifdef PARITY_EN
            par        <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            sreg       <= sreg_n;
            so         <= so_n;
            so_valid   <= so_valid_n;
            frame_done <= frame_done_n;
            din_ready  <= din_ready_n;
`ifdef PARITY_EN
            par        <= par_n;
`endif
        end
    end

endmodule
